// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce.
// Columns are driven low one at a time for SCAN_DIV clocks each. The
// synchronized rows are sampled on the last clock of every column slot,
// and the whole 16-key frame is classified as NONE, SINGLE(code) or MULTI
// at the end of column 3. A debounce FSM, stepped once per frame, accepts
// a key after DEBOUNCE_FRAMES identical SINGLE frames. It releases the key
// after DEBOUNCE_FRAMES consecutive NONE frames.
//
// Output protocol: key_valid is a one-cycle strobe with no back-pressure.
// key is valid in the strobe cycle and holds its value until the next
// accepted press. key_held is a level that is high from acceptance until
// the release is accepted.
//
// Optional feature: define KEYPAD_SCAN_REPEAT_EN to add auto-repeat with
// the parameters REPEAT_DELAY and REPEAT_RATE, both counted in frames.
// When the macro is undefined there is exactly one strobe per press.
module keypad_scan #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_SCAN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] cols,
  input  logic [3:0] rows,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_N     = 8'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  // Scan and synchronizer state
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [15:0] r_div;
  logic [1:0]  r_col;
  // Running frame tally: saturating hit count (0, 1, 2+) and the first hit's code
  logic [1:0]  r_acc_cnt;
  logic [3:0]  r_acc_code;

  // Debounce state
  state_t      r_state;
  logic [3:0]  r_cand;
  logic [7:0]  r_cnt;
  logic [7:0]  r_rel;
  logic [3:0]  r_key;
  logic        r_key_valid;

  // Combinational helpers
  logic        w_slot_end;
  logic        w_frame_end;
  logic [3:0]  w_col_hits;
  logic [2:0]  w_col_num;
  logic [1:0]  w_col_row;
  logic [1:0]  w_tot_cnt;
  logic [3:0]  w_tot_code;
  logic        w_none;
  logic        w_single;
  state_t      w_state_nx;
  logic [3:0]  w_cand_nx;
  logic [7:0]  w_cnt_nx;
  logic [7:0]  w_rel_nx;
  logic        w_accept;
  logic        w_repeat;

  assign w_slot_end  = (r_div == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_col == 2'd3);
  assign w_col_hits  = ~r_sync2;
  assign w_col_num   = 3'(w_col_hits[0]) + 3'(w_col_hits[1])
                     + 3'(w_col_hits[2]) + 3'(w_col_hits[3]);
  assign w_none      = (w_tot_cnt == 2'd0);
  assign w_single    = (w_tot_cnt == 2'd1);

  // Lowest pressed row in the current column; used only when exactly one row is low
  always_comb begin
    w_col_row = 2'd0;
    if (w_col_hits[0])      w_col_row = 2'd0;
    else if (w_col_hits[1]) w_col_row = 2'd1;
    else if (w_col_hits[2]) w_col_row = 2'd2;
    else if (w_col_hits[3]) w_col_row = 2'd3;
  end

  // Fold this slot's row hits into the running tally for the frame
  always_comb begin
    w_tot_cnt  = r_acc_cnt;
    w_tot_code = r_acc_code;
    if (w_col_num >= 3'd2) begin
      w_tot_cnt = 2'd2;
    end else if (w_col_num == 3'd1) begin
      if (r_acc_cnt == 2'd0) begin
        w_tot_cnt  = 2'd1;
        w_tot_code = {w_col_row, r_col};
      end else begin
        w_tot_cnt = 2'd2;
      end
    end
  end

  // Row synchronizer, column slot timing and the frame tally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 4'hF;
      r_sync2    <= 4'hF;
      r_div      <= 16'd0;
      r_col      <= 2'd0;
      r_acc_cnt  <= 2'd0;
      r_acc_code <= 4'd0;
    end else begin
      r_sync1 <= rows;
      r_sync2 <= r_sync1;
      if (w_slot_end) begin
        r_div <= 16'd0;
        r_col <= r_col + 2'd1;
        if (w_frame_end) begin
          r_acc_cnt  <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_cnt  <= w_tot_cnt;
          r_acc_code <= w_tot_code;
        end
      end else begin
        r_div <= r_div + 16'd1;
      end
    end
  end

  // Debounce FSM state register and its counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= 8'd0;
      r_rel       <= 8'd0;
      r_key       <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cand      <= w_cand_nx;
      r_cnt       <= w_cnt_nx;
      r_rel       <= w_rel_nx;
      r_key_valid <= w_accept | w_repeat;
      if (w_accept) r_key <= w_tot_code;
    end
  end

  // Debounce FSM next state; it moves only on the frame's last clock
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_rel_nx   = r_rel;
    w_accept   = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            if (DB_N == 8'd1) begin
              w_accept   = 1'b1;
              w_state_nx = S_HELD;
              w_cnt_nx   = 8'd0;
              w_rel_nx   = 8'd0;
            end else begin
              w_cand_nx  = w_tot_code;
              w_cnt_nx   = 8'd1;
              w_state_nx = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && (w_tot_code == r_cand)) begin
            if (r_cnt + 8'd1 == DB_N) begin
              w_accept   = 1'b1;
              w_state_nx = S_HELD;
              w_cnt_nx   = 8'd0;
              w_rel_nx   = 8'd0;
            end else begin
              w_cnt_nx = r_cnt + 8'd1;
            end
          end else begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = 8'd0;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (r_rel + 8'd1 == DB_N) begin
              w_state_nx = S_IDLE;
              w_rel_nx   = 8'd0;
            end else begin
              w_rel_nx = r_rel + 8'd1;
            end
          end else begin
            w_rel_nx = 8'd0;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = 8'd0;
          w_rel_nx   = 8'd0;
        end
      endcase
    end
  end

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam logic [15:0] REP_DELAY_N = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_RATE_N  = 16'(REPEAT_RATE);

  logic [15:0] r_rep;
  logic        r_rep_armed;
  logic [15:0] w_rep_nx;
  logic        w_rep_armed_nx;

  // Auto-repeat: frames of the held key count toward the delay, then toward the rate
  always_comb begin
    w_rep_nx       = r_rep;
    w_rep_armed_nx = r_rep_armed;
    w_repeat       = 1'b0;
    if (r_state != S_HELD) begin
      w_rep_nx       = 16'd0;
      w_rep_armed_nx = 1'b0;
    end else if (w_frame_end) begin
      if (w_single && (w_tot_code == r_key)) begin
        if (!r_rep_armed) begin
          if (r_rep + 16'd1 == REP_DELAY_N) begin
            w_repeat       = 1'b1;
            w_rep_armed_nx = 1'b1;
            w_rep_nx       = 16'd0;
          end else begin
            w_rep_nx = r_rep + 16'd1;
          end
        end else if (r_rep + 16'd1 == REP_RATE_N) begin
          w_repeat = 1'b1;
          w_rep_nx = 16'd0;
        end else begin
          w_rep_nx = r_rep + 16'd1;
        end
      end else begin
        w_rep_nx       = 16'd0;
        w_rep_armed_nx = 1'b0;
      end
    end
  end

  // Auto-repeat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep       <= 16'd0;
      r_rep_armed <= 1'b0;
    end else begin
      r_rep       <= w_rep_nx;
      r_rep_armed <= w_rep_armed_nx;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // Outputs: one-hot-low column drive and the registered key interface
  always_comb begin
    cols = 4'b1110;
    case (r_col)
      2'd0:    cols = 4'b1110;
      2'd1:    cols = 4'b1101;
      2'd2:    cols = 4'b1011;
      2'd3:    cols = 4'b0111;
      default: cols = 4'b1110;
    endcase
    key       = r_key;
    key_valid = r_key_valid;
    key_held  = (r_state == S_HELD);
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clocks each column stays driven; legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames needed for a press or a release; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cols  output  4  column drive, active-low, exactly one bit low at any time.
REQ-006 SHALL have port rows  input  4  row sense, active-low, asynchronous to clk (external pull-ups).
REQ-007 SHALL have port key  output  4  code of last accepted key = {row_index[1:0], col_index[1:0]}.
REQ-008 SHALL have port key_valid  output  1  one-cycle strobe, key is valid in the same cycle.
REQ-009 SHALL have port key_held  output  1  level, high while an accepted key has not yet been released.

Function
REQ-010 SHALL pass rows through a two-flop synchronizer before use.
REQ-011 SHALL drive column c (c = 0..3, cols[c] = 0) for SCAN_DIV clocks, then advance to c+1, wrapping 3 -> 0; one frame = 4*SCAN_DIV clocks.
REQ-012 SHALL sample the synchronized rows only on the last clock of each column slot.
REQ-013 SHALL classify each frame at its end as NONE (0 pressed), SINGLE(code) (exactly 1 pressed), or MULTI (2 or more pressed).
REQ-014 SHALL implement states IDLE, DEBOUNCE, HELD, evaluated only at frame end.
REQ-015 IDLE: SINGLE(code) -> store candidate = code, set count = 1, go to DEBOUNCE. NONE or MULTI -> stay in IDLE.
REQ-016 DEBOUNCE: SINGLE(same candidate) -> count++. NONE, MULTI or a different code -> go to IDLE with count = 0.
REQ-017 When count reaches DEBOUNCE_FRAMES: set key = candidate, pulse key_valid for exactly 1 cycle, set key_held = 1, go to HELD. With DEBOUNCE_FRAMES = 1, the first SINGLE frame accepts immediately from IDLE.
REQ-018 HELD: each NONE frame increments the release count; any non-NONE frame clears it. When the release count reaches DEBOUNCE_FRAMES: key_held = 0, go to IDLE.
REQ-019 SHALL ignore MULTI and key changes while in HELD; no new strobe until a release is accepted.
REQ-020 key SHALL hold its value until the next accepted press, including after release.
REQ-021 key_valid SHALL assert no more than once per frame and never in consecutive cycles.

Reset
REQ-022 While rst is high: cols = 4'b1110, column slot counter = 0, synchronizer flops = 4'hF, state = IDLE, all counts = 0, key = 0, key_valid = 0, key_held = 0.
REQ-023 Reset asserted mid-frame or in any state SHALL abort the frame with no strobe. The first frame after reset starts at column 0 on the cycle after rst deasserts.

Configuration
REQ-024 Macro KEYPAD_SCAN_REPEAT_EN, when defined, SHALL add parameters REPEAT_DELAY (default 32 frames) and REPEAT_RATE (default 8 frames).
REQ-025 With KEYPAD_SCAN_REPEAT_EN defined, in HELD: after REPEAT_DELAY frames, key_valid SHALL re-pulse with an unchanged key every REPEAT_RATE frames. Repeat counting runs only while the frame is SINGLE(key) and restarts on any other frame.
REQ-026 Without KEYPAD_SCAN_REPEAT_EN: no repeat logic, no extra parameters, exactly one key_valid per accepted press.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 clocks)
REQ-027 Hold row 2 low whenever cols[1] = 0 for 5 frames -> single key_valid at end of frame 3, key = 4'h9, key_held = 1; after rows go idle, key_held = 0 at end of 3rd empty frame.
REQ-028 Same press lasting only 2 frames, then 1 empty frame -> no key_valid, state back to IDLE, key still 0.
REQ-029 Rows 0 and 3 low under column 2 for 6 frames -> MULTI every frame, no key_valid; then release, then row 3 only for 3 frames -> key_valid with key = 4'hE.
REQ-030 Accept key 4'h5, then bounce: NONE, NONE, SINGLE, NONE x3 -> key_held stays 1 until the 3rd consecutive NONE, and no second strobe.
REQ-031 Assert rst for 1 cycle during frame 2 of a debounce -> outputs at reset values, cols = 4'b1110 next cycle, press re-debounced from zero (strobe 3 full frames later).
REQ-032 With KEYPAD_SCAN_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, hold key 4'h0 for 12 frames -> strobes at frames 3, 7, 9, 11.
